// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial scan controller: serialises framed words MSB-first and counts
// runtime-configured bit-pattern matches. Optional output match_pos under `MATCH_POS_EN.
module pattern_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PAT_MAX-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_MAX):0]   cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       match_pulse,
  output logic                       done,
  output logic [CNT_W-1:0]           match_count,
`ifdef MATCH_POS_EN
  output logic [15:0]                match_pos,
`endif
  output logic                       overflow
);

  localparam int LEN_W = $clog2(PAT_MAX) + 1;
  localparam int CW    = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  word_r;
  logic               last_r;
  logic [CW-1:0]      cnt_r;
  logic [PAT_MAX-1:0] window_r;
  logic [LEN_W-1:0]   seen_r;
  logic [PAT_MAX-1:0] pat_r;
  logic [PAT_MAX-1:0] mask_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
`ifdef MATCH_POS_EN
  logic [15:0]        pos_idx_r;
`endif

  logic               accept_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [PAT_MAX-1:0] len_mask_s;
  logic [PAT_MAX-1:0] window_nx_s;
  logic [LEN_W-1:0]   seen_inc_s;
  logic               hit_s;

  assign accept_s = in_valid & in_ready;

  // Clamp the requested length and build the compare mask for the low len bits.
  always_comb begin
    if (cfg_len > LEN_W'(PAT_MAX)) begin
      len_clamp_s = LEN_W'(PAT_MAX);
    end else begin
      len_clamp_s = cfg_len;
    end
    len_mask_s = {PAT_MAX{1'b0}};
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask_s[i] = (LEN_W'(i) < len_clamp_s);
    end
  end

  // Next window/seen values and the match decision for the bit shifted this cycle.
  always_comb begin
    window_nx_s = {window_r[PAT_MAX-2:0], word_r[DATA_W-1]};
    if (seen_r >= LEN_W'(PAT_MAX)) begin
      seen_inc_s = seen_r;
    end else begin
      seen_inc_s = seen_r + LEN_W'(1);
    end
    if ((len_r != {LEN_W{1'b0}}) && (seen_inc_s >= len_r) &&
        ((window_nx_s & mask_r) == pat_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      word_r      <= {DATA_W{1'b0}};
      last_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      window_r    <= {PAT_MAX{1'b0}};
      seen_r      <= {LEN_W{1'b0}};
      pat_r       <= {PAT_MAX{1'b0}};
      mask_r      <= {PAT_MAX{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      ovl_r       <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      match_count <= {CNT_W{1'b0}};
      overflow    <= 1'b0;
`ifdef MATCH_POS_EN
      pos_idx_r   <= 16'h0000;
      match_pos   <= 16'hFFFF;
`endif
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            word_r   <= in_data;
            last_r   <= in_last;
            cnt_r    <= {CW{1'b0}};
            in_ready <= 1'b0;
            state_r  <= ST_SHIFT;
            // Config is captured only on the first word; later changes are ignored.
            if (!busy) begin
              pat_r       <= cfg_pattern & len_mask_s;
              mask_r      <= len_mask_s;
              len_r       <= len_clamp_s;
              ovl_r       <= cfg_overlap;
              window_r    <= {PAT_MAX{1'b0}};
              seen_r      <= {LEN_W{1'b0}};
              match_count <= {CNT_W{1'b0}};
              overflow    <= 1'b0;
              busy        <= 1'b1;
`ifdef MATCH_POS_EN
              pos_idx_r   <= 16'h0000;
              match_pos   <= 16'hFFFF;
`endif
            end
          end
        end
        ST_SHIFT: begin
          word_r   <= word_r << 1;
          window_r <= window_nx_s;
          if (hit_s) begin
            match_pulse <= 1'b1;
            if (match_count == {CNT_W{1'b1}}) begin
              overflow <= 1'b1;
            end else begin
              match_count <= match_count + CNT_W'(1);
            end
            // Non-overlapping mode restarts the bit history so no bit is reused.
            seen_r <= ovl_r ? seen_inc_s : {LEN_W{1'b0}};
`ifdef MATCH_POS_EN
            if (match_pos == 16'hFFFF) begin
              match_pos <= pos_idx_r;
            end
`endif
          end else begin
            seen_r <= seen_inc_s;
          end
`ifdef MATCH_POS_EN
          if (pos_idx_r != 16'hFFFE) begin
            pos_idx_r <= pos_idx_r + 16'd1;
          end
`endif
          if (cnt_r == CW'(DATA_W - 1)) begin
            cnt_r <= {CW{1'b0}};
            if (last_r) begin
              state_r <= ST_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r  <= ST_IDLE;
              in_ready <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_FIN: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: per-cycle compare against a frame-level
// model (bit list + match rules) under directed and randomized stimulus.
module tb_pattern_scan_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = $clog2(PAT_MAX) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_last = 1'b0;
  logic               in_ready, busy, match_pulse, done, overflow;
  logic [CNT_W-1:0]   match_count;
`ifdef MATCH_POS_EN
  logic [15:0]        match_pos;
`endif

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse), .done(done),
    .match_count(match_count),
`ifdef MATCH_POS_EN
    .match_pos(match_pos),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int pulse_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic             rdy;
    logic             bsy;
    logic             pls;
    logic             dn;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [15:0]      pos;
  } exp_t;

  exp_t   q[$];
  exp_t   cur;
  int     m_bits[$];
  int     m_hits[$];
  int     m_last_hit;
  logic [PAT_MAX-1:0] m_pat;
  int     m_len;
  bit     m_ovl;
  int     m_cnt;
  bit     m_ovf;
  int     m_pos;

  function automatic bit model_hit(input int i);
    if (m_len == 0 || i < m_len - 1) return 1'b0;
    if (!m_ovl && m_last_hit >= 0 && (i - m_last_hit) < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++)
      if (m_bits[i-j] != int'(m_pat[j])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    cur = '{rdy: 1'b1, bsy: 1'b0, pls: 1'b0, dn: 1'b0, cnt: '0, ovf: 1'b0, pos: 16'hFFFF};
    m_cnt = 0; m_ovf = 0; m_pos = 16'hFFFF;
  endtask

  task automatic model_step();
    exp_t e;
    if (in_valid && cur.rdy) begin
      if (!cur.bsy) begin
        m_pat = cfg_pattern;
        m_len = (int'(cfg_len) > PAT_MAX) ? PAT_MAX : int'(cfg_len);
        m_ovl = cfg_overlap;
        m_bits.delete(); m_hits.delete(); m_last_hit = -1;
        m_cnt = 0; m_ovf = 0; m_pos = 16'hFFFF;
      end
      e = '{rdy: 1'b0, bsy: 1'b1, pls: 1'b0, dn: 1'b0, cnt: CNT_W'(m_cnt), ovf: m_ovf, pos: 16'(m_pos)};
      q.push_back(e);
      for (int k = 0; k < DATA_W; k++) begin
        int i;
        bit h;
        m_bits.push_back(int'(in_data[DATA_W-1-k]));
        i = m_bits.size() - 1;
        h = model_hit(i);
        if (h) begin
          m_hits.push_back(i);
          m_last_hit = i;
          if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1; else m_cnt++;
          if (m_pos == 16'hFFFF) m_pos = (i > 16'hFFFE) ? 16'hFFFE : i;
        end
        e.pls = h; e.cnt = CNT_W'(m_cnt); e.ovf = m_ovf; e.pos = 16'(m_pos);
        if (k == DATA_W - 1) begin
          e.dn = in_last; e.bsy = !in_last; e.rdy = !in_last;
        end
        q.push_back(e);
      end
    end
    if (q.size() > 0) cur = q.pop_front();
    else begin
      cur.pls = 1'b0; cur.dn = 1'b0; cur.rdy = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match_pulse", 32'(match_pulse), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match_count", 32'(match_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(cur.rdy));
        chk("busy", 32'(busy), 32'(cur.bsy));
        chk("match_pulse", 32'(match_pulse), 32'(cur.pls));
        chk("done", 32'(done), 32'(cur.dn));
        chk("match_count", 32'(match_count), 32'(cur.cnt));
        chk("overflow", 32'(overflow), 32'(cur.ovf));
`ifdef MATCH_POS_EN
        chk("match_pos", 32'(match_pos), 32'(cur.pos));
`endif
      end
      if (done === 1'b1) done_seen++;
      if (match_pulse === 1'b1) pulse_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_cyc;

  task automatic set_cfg(input logic [PAT_MAX-1:0] p, input int l, input bit o);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit last);
    bit acc = 0;
    logic r;
    in_data = d; in_last = last; in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r === 1'b1) acc = 1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted (t=%0t)", $time);
    end
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int done_cyc;
  logic [CNT_W-1:0] done_cnt;
  logic done_ovf;

  task automatic wait_done();
    bit got = 0;
    in_valid = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1; done_cyc = cyc; done_cnt = match_count; done_ovf = overflow;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done (t=%0t)", $time);
    end
    @(posedge clk); #1;
  endtask

  int p0, d0, first_acc;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Non-overlap 101 over 8'hAA: matches at bits 2 and 6.
    set_cfg(8'b101, 3, 1'b0);
    p0 = pulse_seen;
    send(8'hAA, 1'b1);
    wait_done();
    chk("nonovl_count", 32'(done_cnt), 32'd2);
    chk("nonovl_pulses", 32'(pulse_seen - p0), 32'd2);
    chk("nonovl_model_nhits", 32'(m_hits.size()), 32'd2);
    chk("nonovl_model_hit0", 32'(m_hits[0]), 32'd2);
    chk("nonovl_model_hit1", 32'(m_hits[1]), 32'd6);
`ifdef MATCH_POS_EN
    chk("nonovl_pos", 32'(match_pos), 32'd2);
`endif

    // Overlap mode: matches at 2, 4, 6.
    set_cfg(8'b101, 3, 1'b1);
    send(8'hAA, 1'b1);
    wait_done();
    chk("ovl_count", 32'(done_cnt), 32'd3);
    chk("ovl_model_hit1", 32'(m_hits[1]), 32'd4);

    // Cross-word: 01 then 40 back-to-back, one match at frame bit 9.
    set_cfg(8'b101, 3, 1'b0);
    send(8'h01, 1'b0);
    first_acc = acc_cyc;
    send(8'h40, 1'b1);
    chk("xword_accept_gap", 32'(acc_cyc - first_acc), 32'(DATA_W + 1));
    wait_done();
    chk("xword_count", 32'(done_cnt), 32'd1);
    chk("xword_model_hit0", 32'(m_hits[0]), 32'd9);
    // done is registered on the 17th edge after the accepting edge (18th cycle).
    chk("xword_latency", 32'(done_cyc - first_acc), 32'd17);

    // Saturation of the 4-bit counter: 16 matches.
    set_cfg(8'h01, 1, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    wait_done();
    chk("sat_count", 32'(done_cnt), 32'd15);
    chk("sat_overflow", 32'(done_ovf), 32'd1);

    // Backpressure with mid-frame config change: AA,55 under 101 non-overlap -> 4.
    set_cfg(8'b101, 3, 1'b0);
    send(8'hAA, 1'b0);
    first_acc = acc_cyc;
    set_cfg(8'b1, 1, 1'b1);
    send(8'h55, 1'b1);
    chk("bp_accept_gap", 32'(acc_cyc - first_acc), 32'(DATA_W + 1));
    wait_done();
    chk("bp_count", 32'(done_cnt), 32'd4);

    // cfg_len = 0 never matches; over-long length clamps to PAT_MAX.
    set_cfg(8'hFF, 0, 1'b1);
    send(8'hFF, 1'b1);
    wait_done();
    chk("len0_count", 32'(done_cnt), 32'd0);
    set_cfg(8'hFF, 15, 1'b1);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    wait_done();
    chk("clamp_count", 32'(done_cnt), 32'd9);

    // Reset in the middle of shifting: no done, next frame counts from zero.
    set_cfg(8'b101, 3, 1'b0);
    d0 = done_seen;
    send(8'hAA, 1'b1);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle(8);
    chk("midrst_no_done", 32'(done_seen - d0), 32'd0);
    send(8'hAA, 1'b1);
    wait_done();
    chk("postrst_count", 32'(done_cnt), 32'd2);

    // Randomized frames, random gaps and mid-frame config churn.
    for (int f = 0; f < 40; f++) begin
      int nw;
      set_cfg(PAT_MAX'($urandom), $urandom_range(0, 15), 1'($urandom));
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        if (w > 0 && ($urandom % 3) == 0)
          set_cfg(PAT_MAX'($urandom), $urandom_range(0, 15), 1'($urandom));
        send(DATA_W'($urandom), w == nw - 1);
        if (($urandom % 2) == 0) idle($urandom_range(0, 3));
      end
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Word-to-serial scan controller that feeds a programmable serial sequence matcher. It accepts DATA_W-bit words over a valid/ready handshake and groups them into frames delimited by in_last. Each word is serialised MSB-first, one bit per clock, and the block counts occurrences of a runtime-configured bit pattern in overlapping or non-overlapping mode. It schedules the serial detector datapath for upstream word-oriented requesters and reports per-frame results.

Parameters:
DATA_W, 8, width of each input word
PAT_MAX, 8, maximum pattern length in bits
CNT_W, 8, width of the match counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; asynchronous, active-low
cfg_pattern  in  PAT_MAX  pattern; bit 0 = most recent bit, bit len-1 = oldest
cfg_len  in  $clog2(PAT_MAX)+1  pattern length in bits
cfg_overlap  in  1  1 = overlapping detection; 0 = non-overlapping
in_valid  in  1  word valid
in_data  in  DATA_W  word, scanned MSB first
in_last  in  1  word is last of frame
in_ready  out  1  block can accept a word
busy  out  1  frame in progress
match_pulse  out  1  one-cycle pulse per detected match
done  out  1  one-cycle pulse at frame end
match_count  out  CNT_W  matches in current/last frame
overflow  out  1  sticky counter saturation flag for the frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; busy=0; match_pulse=0; done=0; match_count=0; overflow=0; window and bit counter cleared. Reset mid-frame abandons the frame with no done pulse.
- FSM states:
  - IDLE: in_ready=1. Exits on accept.
  - SHIFT: in_ready=0 for DATA_W cycles.
  - FIN: done=1 for one cycle, then IDLE.
- Accept: in_valid & in_ready at a clock edge.
  - Latch in_data and in_last; go to SHIFT.
  - If busy=0, the accept starts a new frame: sample cfg_pattern, cfg_len and cfg_overlap; clear window, seen-count, match_count and overflow; set busy=1.
  - Config changes mid-frame are ignored.
- SHIFT: each cycle, shift the next bit (MSB first) into a PAT_MAX-bit window. seen = min(seen+1, PAT_MAX).
- Match condition: seen >= len, and window[len-1:0] == pattern[len-1:0].
  - match_pulse is registered and asserts the cycle after the matching bit's shift cycle.
  - Non-overlap mode: on a match, seen resets to 0, so no bit is reused.
  - Overlap mode: seen is unaffected.
- Window and seen persist across word boundaries within a frame; patterns may straddle words.
- After DATA_W shift cycles:
  - in_last=1: go to FIN, busy drops with done.
  - Otherwise: go to IDLE with busy held at 1.
- Throughput is one word per DATA_W+1 cycles.
- match_count: increments on each match and saturates at 2^CNT_W-1. A match while saturated sets overflow. Both hold after done until the next frame starts.
- cfg_len edge cases:
  - cfg_len=0: no matches ever.
  - cfg_len>PAT_MAX: clamped to PAT_MAX.
- Backpressure: in_valid held while in_ready=0 is not consumed. in_data and in_last must stay stable until accepted.
- A match on the final bit of a frame: match_pulse and done assert in the same cycle, and the count includes that match.

Optional Feature:
MATCH_POS_EN:
- Defined: adds output match_pos [15:0], the frame-relative index (first bit = 0) of the first match in the frame. Cleared at frame start; holds the first match until the next frame. Reads 16'hFFFF if the frame had no match. The index saturates at 16'hFFFE.
- Undefined: port and logic are absent.

Test Plan:
- Non-overlap: pattern 3'b101, len 3, overlap=0, single word 8'hAA with in_last=1 -> match_pulse for bit indices 2 and 6; done with match_count=2; match_pos=2.
- Overlap: same stimulus with overlap=1 -> matches at bits 2, 4, 6; match_count=3.
- Cross-word: pattern 101, len 3, words 8'h01 then 8'h40 (last) -> one match at frame bit 9; match_count=1; done 18 cycles after the first accept with back-to-back valid.
- Saturation: CNT_W=4, pattern 1'b1, len 1, two words 8'hFF -> match_count=15; overflow=1 at done.
- Backpressure and config: in_valid held during SHIFT, and cfg_len changed mid-frame -> second word accepted only when in_ready=1; results use the original config; no word duplicated or dropped.
- Reset mid-SHIFT: assert rst_n=0 at shift cycle 4 -> all outputs at reset values immediately; no done; next frame counts from 0.
